// File: rtl/rs232_rx_frame_ctrl.sv
// Frame parser for a UART receiver byte stream: SOF, LEN, payload, CSUM.
// Emits payload strobes and a frame verdict, and pulses the receiver flush after bad frames.
module rs232_rx_frame_ctrl #(
    parameter logic [7:0]  SOF_BYTE     = 8'hA5,
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned FLUSH_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset_neg,
    input  logic       rx_dataout_ready,
    input  logic [7:0] rx_dataout,
    input  logic       rx_endofpacket,
    output logic       rx_flush,
    output logic       pl_valid,
    output logic [7:0] pl_data,
    output logic [7:0] pl_index,
    output logic       pkt_done,
    output logic       pkt_ok,
    output logic [1:0] err_code,
    output logic [7:0] pkt_len,
    output logic [7:0] good_count,
    output logic [7:0] bad_count
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned FCNT_W  = 4;
    localparam int unsigned ERR_W   = 2;

    localparam logic [BYTE_W-1:0] MAX_LEN_B  = BYTE_W'(MAX_LEN);
    localparam logic [FCNT_W-1:0] FLUSH_LAST = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [BYTE_W-1:0] CNT_SAT    = 8'hFF;

    localparam logic [ERR_W-1:0] ERR_NONE = 2'd0;
    localparam logic [ERR_W-1:0] ERR_LEN  = 2'd1;
    localparam logic [ERR_W-1:0] ERR_CSUM = 2'd2;
    localparam logic [ERR_W-1:0] ERR_GAP  = 2'd3;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic [BYTE_W-1:0]   acc_q, acc_d;
    logic [BYTE_W-1:0]   idx_q, idx_d;
    logic [BYTE_W-1:0]   len_q, len_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;

    logic                rx_flush_d;
    logic                pl_valid_d;
    logic [BYTE_W-1:0]   pl_data_d;
    logic [BYTE_W-1:0]   pl_index_d;
    logic                pkt_done_d;
    logic                pkt_ok_d;
    logic [ERR_W-1:0]    err_code_d;
    logic [BYTE_W-1:0]   pkt_len_d;
    logic [BYTE_W-1:0]   good_count_d;
    logic [BYTE_W-1:0]   bad_count_d;

    logic                fin;
    logic [ERR_W-1:0]    fin_err;
    logic [BYTE_W-1:0]   fin_len;
    logic [BYTE_W-1:0]   sum_c;

    assign sum_c = acc_q + rx_dataout;

    // State and output registers
    always_ff @(posedge clock or negedge reset_neg) begin
        if (!reset_neg) begin
            state_q    <= ST_HUNT;
            acc_q      <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            fcnt_q     <= '0;
            rx_flush   <= 1'b0;
            pl_valid   <= 1'b0;
            pl_data    <= '0;
            pl_index   <= '0;
            pkt_done   <= 1'b0;
            pkt_ok     <= 1'b0;
            err_code   <= '0;
            pkt_len    <= '0;
            good_count <= '0;
            bad_count  <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            fcnt_q     <= fcnt_d;
            rx_flush   <= rx_flush_d;
            pl_valid   <= pl_valid_d;
            pl_data    <= pl_data_d;
            pl_index   <= pl_index_d;
            pkt_done   <= pkt_done_d;
            pkt_ok     <= pkt_ok_d;
            err_code   <= err_code_d;
            pkt_len    <= pkt_len_d;
            good_count <= good_count_d;
            bad_count  <= bad_count_d;
        end
    end

    // Next-state and next-output logic; a byte strobe takes priority over a gap timeout
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        len_d        = len_q;
        fcnt_d       = fcnt_q;
        rx_flush_d   = 1'b0;
        pl_valid_d   = 1'b0;
        pl_data_d    = pl_data;
        pl_index_d   = pl_index;
        pkt_done_d   = 1'b0;
        pkt_ok_d     = pkt_ok;
        err_code_d   = err_code;
        pkt_len_d    = pkt_len;
        good_count_d = good_count;
        bad_count_d  = bad_count;
        fin          = 1'b0;
        fin_err      = ERR_NONE;
        fin_len      = len_q;

        unique case (state_q)
            ST_HUNT: begin
                if (rx_dataout_ready && (rx_dataout == SOF_BYTE)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_dataout_ready) begin
                    if ((rx_dataout == '0) || (rx_dataout > MAX_LEN_B)) begin
                        fin     = 1'b1;
                        fin_err = ERR_LEN;
                        fin_len = rx_dataout;
                    end else begin
                        len_d   = rx_dataout;
                        acc_d   = rx_dataout;
                        idx_d   = '0;
                        state_d = ST_PAYLOAD;
                    end
                end else if (rx_endofpacket) begin
                    fin     = 1'b1;
                    fin_err = ERR_GAP;
                    fin_len = '0;
                end
            end
            ST_PAYLOAD: begin
                if (rx_dataout_ready) begin
                    acc_d      = sum_c;
                    pl_valid_d = 1'b1;
                    pl_data_d  = rx_dataout;
                    pl_index_d = idx_q;
                    idx_d      = idx_q + 8'd1;
                    if (idx_q == (len_q - 8'd1)) begin
                        state_d = ST_CSUM;
                    end
                end else if (rx_endofpacket) begin
                    fin     = 1'b1;
                    fin_err = ERR_GAP;
                end
            end
            ST_CSUM: begin
                if (rx_dataout_ready) begin
                    fin     = 1'b1;
                    fin_err = (sum_c == '0) ? ERR_NONE : ERR_CSUM;
                end else if (rx_endofpacket) begin
                    fin     = 1'b1;
                    fin_err = ERR_GAP;
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = ST_HUNT;
                end else begin
                    fcnt_d     = fcnt_q - 4'd1;
                    rx_flush_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        // Frame termination: verdict, counters, and flush entry on error
        if (fin) begin
            pkt_done_d = 1'b1;
            pkt_ok_d   = (fin_err == ERR_NONE);
            err_code_d = fin_err;
            pkt_len_d  = fin_len;
            if (fin_err == ERR_NONE) begin
                state_d = ST_HUNT;
                if (good_count != CNT_SAT) begin
                    good_count_d = good_count + 8'd1;
                end
            end else begin
                state_d    = ST_FLUSH;
                fcnt_d     = FLUSH_LAST;
                rx_flush_d = 1'b1;
                if (bad_count != CNT_SAT) begin
                    bad_count_d = bad_count + 8'd1;
                end
            end
        end
    end

endmodule
